// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the multicycle-aware hazard unit.
//   fwd_sel_e  : E-stage operand forwarding mux select
//   PCSRC_*    : encodings of the E-stage next-PC source
//   mc_state_e : occupancy state of the multicycle unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/mc_scoreboard.sv
// mc_scoreboard: tracks one in-flight long-latency EX operation.
//   clk, rst     : clock, asynchronous active-high reset
//   accept_i     : multicycle op accepted in E this cycle
//   rd_i         : destination register of the accepted op
//   memwait_i    : data-memory wait state (result pulse is deferred)
//   busy_o       : unit occupied
//   done_o       : 1-cycle pulse, result ready for write-back
//   rd_o         : destination of the in-flight op
//   pending_o    : per-register pending bits (bit 0 never set)
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 34,
  parameter int unsigned CNT_W  = $clog2(MC_LAT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   accept_i,
  input  logic [REG_AW-1:0]      rd_i,
  input  logic                   memwait_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [REG_AW-1:0]      rd_o,
  output logic [2**REG_AW-1:0]   pending_o
);

  mc_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_AW-1:0]     rd_q, rd_d;
  logic [2**REG_AW-1:0]  sb_q, sb_d;
  logic                  done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    sb_d    = sb_q;
    done    = 1'b0;

    if (state_q == MC_BUSY) begin
      if (cnt_q != '0) begin
        // keeps counting through memory wait states
        cnt_d = cnt_q - CNT_W'(1);
      end else if (!memwait_i) begin
        done          = 1'b1;
        state_d       = MC_IDLE;
        sb_d[rd_q]    = 1'b0;
      end
    end

    // applied after the clear so a same-edge set of the same register wins
    if (accept_i) begin
      state_d = MC_BUSY;
      cnt_d   = CNT_W'(MC_LAT - 1);
      rd_d    = rd_i;
      if (rd_i != '0) sb_d[rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      sb_q    <= sb_d;
    end
  end

  assign busy_o    = (state_q == MC_BUSY);
  assign done_o    = done;
  assign rd_o      = rd_q;
  assign pending_o = sb_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard unit for the 5-stage RV32I pipeline with a
// multicycle EX unit scoreboard and data-memory wait-state freeze.
//   Inputs : D/E/M/W register indices and write enables, E-stage pcsrc,
//            load and multicycle-start flags, dmem request/ready.
//   Outputs: stage stalls (F/D/E/M), flushes (D/E/W), E operand forwarding
//            selects, multicycle busy/done/destination.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 34,
  parameter int unsigned CNT_W  = $clog2(MC_LAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic [REG_AW-1:0] rd_d_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic [1:0]        pcsrc_e_i,
  input  logic              result_src_e_i,
  input  logic              mc_start_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic              dmem_req_m_i,
  input  logic              dmem_ready_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              stall_e_o,
  output logic              stall_m_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic              flush_w_o,
  output logic [1:0]        forward_ae_o,
  output logic [1:0]        forward_be_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [REG_AW-1:0] mc_rd_o
);

  logic                 memwait;
  logic                 accept;
  logic                 load_use;
  logic                 sb_hit;
  logic                 struct_haz;
  logic [2**REG_AW-1:0] pending;

  assign memwait    = dmem_req_m_i & ~dmem_ready_i;
  assign accept     = mc_start_e_i & ~mc_busy_o & ~memwait & (pcsrc_e_i == PCSRC_SEQ);
  assign load_use   = result_src_e_i & (rd_e_i != '0) &
                      ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i));
  assign sb_hit     = pending[rs1_d_i] | pending[rs2_d_i] | pending[rd_d_i];
  assign struct_haz = mc_start_e_i & mc_busy_o;

  mc_scoreboard #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .accept_i  (accept),
    .rd_i      (rd_e_i),
    .memwait_i (memwait),
    .busy_o    (mc_busy_o),
    .done_o    (mc_done_o),
    .rd_o      (mc_rd_o),
    .pending_o (pending)
  );

  // M beats W; x0 and registers awaiting a multicycle result never forward
  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs);
    if (rs == '0 || pending[rs])                  return FWD_RF;
    else if (reg_write_m_i && rd_m_i == rs)       return FWD_M;
    else if (reg_write_w_i && rd_w_i == rs)       return FWD_W;
    else                                          return FWD_RF;
  endfunction

  always_comb begin
    stall_f_o    = 1'b0;
    stall_d_o    = 1'b0;
    stall_e_o    = 1'b0;
    stall_m_o    = 1'b0;
    flush_d_o    = 1'b0;
    flush_e_o    = 1'b0;
    flush_w_o    = 1'b0;
    forward_ae_o = fwd_sel(rs1_e_i);
    forward_be_o = fwd_sel(rs2_e_i);

    if (rst) begin
      flush_d_o    = 1'b1;
      flush_e_o    = 1'b1;
      flush_w_o    = 1'b1;
      forward_ae_o = FWD_RF;
      forward_be_o = FWD_RF;
    end else if (memwait) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (pcsrc_e_i != PCSRC_SEQ) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (struct_haz) begin
      // E is held, so it must not also be flushed; M receives the bubble
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
    end else if (load_use | sb_hit) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] pcsrc;
  logic       ld, mcs, rw_m, dreq, drdy, rw_w;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] fa, fb;
  logic       busy, done;
  logic [4:0] mc_rd;
  logic [10:0] outv;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MC_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rd_d_i(rd_d),
    .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .pcsrc_e_i(pcsrc), .result_src_e_i(ld), .mc_start_e_i(mcs),
    .rd_m_i(rd_m), .reg_write_m_i(rw_m),
    .dmem_req_m_i(dreq), .dmem_ready_i(drdy),
    .rd_w_i(rd_w), .reg_write_w_i(rw_w),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
    .flush_d_o(flush_d), .flush_e_o(flush_e), .flush_w_o(flush_w),
    .forward_ae_o(fa), .forward_be_o(fb),
    .mc_busy_o(busy), .mc_done_o(done), .mc_rd_o(mc_rd)
  );

  assign outv = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fa, fb};

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e;
    logic [1:0] pcsrc;
    logic       ld, mcs;
    logic [4:0] rd_m;
    logic       rw_m, dreq, drdy;
    logic [4:0] rd_w;
    logic       rw_w;
    logic [3:0] stall;
    logic [2:0] flush;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    rs1_d = '0; rs2_d = '0; rd_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    pcsrc = '0; ld = 1'b0; mcs = 1'b0; rd_m = '0; rw_m = 1'b0;
    dreq = 1'b0; drdy = 1'b0; rd_w = '0; rw_w = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; rd_d = v.rd_d;
    rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e;
    pcsrc = v.pcsrc; ld = v.ld; mcs = v.mcs;
    rd_m = v.rd_m; rw_m = v.rw_m; dreq = v.dreq; drdy = v.drdy;
    rd_w = v.rd_w; rw_w = v.rw_w;
  endtask

  task automatic accept_div();
    @(negedge clk);
    clr_in();
    mcs = 1'b1; rd_e = 5'd9;
    #1 check("div pre-accept busy", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // fields: rs1_d rs2_d rd_d rs1_e rs2_e rd_e pcsrc ld mcs rd_m rw_m dreq drdy rd_w rw_w | stall{fdem} flush{dew} fa fb
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[1]  = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 4'b0000, 3'b000, 2'b10, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b01};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 4'b0000, 3'b000, 2'b01, 2'b00};
    vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100, 3'b010, 2'b00, 2'b00};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 2'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b110, 2'b00, 2'b00};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b110, 2'b00, 2'b00};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'b1111, 3'b001, 2'b00, 2'b00};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 2'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 4'b0000, 3'b000, 2'b10, 2'b10};

    // reset state, with inputs that would otherwise forward and stall
    clr_in();
    rst = 1'b1;
    rs1_e = 5'd5; rd_m = 5'd5; rw_m = 1'b1;
    ld = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    #12;
    check("reset outputs", 32'(outv), 32'({4'b0000, 3'b111, 2'b00, 2'b00}));
    check("reset busy/done/mc_rd", 32'({busy, done, mc_rd}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clr_in();

    // combinational vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 check($sformatf("vec%0d outputs", i), 32'(outv),
               32'({vecs[i].stall, vecs[i].flush, vecs[i].fa, vecs[i].fb}));
    end

    // load-use: one stall cycle, then the load result is taken from W
    @(negedge clk);
    clr_in(); ld = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    #1 check("lu stall", 32'(outv), 32'({4'b1100, 3'b010, 2'b00, 2'b00}));
    @(negedge clk);
    clr_in(); rd_m = 5'd7; rw_m = 1'b1; rs2_d = 5'd7;
    #1 check("lu release", 32'(outv), 32'd0);
    @(negedge clk);
    clr_in(); rd_w = 5'd7; rw_w = 1'b1; rs2_e = 5'd7;
    #1 check("lu fwd W", 32'(fb), 32'd1);

    // multicycle op with dependent in D, structural hazard on a second start
    accept_div();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      clr_in(); rs1_d = 5'd9;
      if (k == 1) begin rd_m = 5'd9; rw_m = 1'b1; rs1_e = 5'd9; end
      if (k == 2) begin mcs = 1'b1; rd_e = 5'd10; end
      #1;
      if (k == 1) begin
        check("div busy/mc_rd", 32'({busy, mc_rd}), 32'({1'b1, 5'd9}));
        check("div pending no fwd", 32'(fa), 32'd0);
      end
      if (k == 2)
        check("div structural", 32'({stall_f, stall_d, stall_e, stall_m, flush_e}), 32'(5'b11100));
      check($sformatf("div done c%0d", k), 32'(done), 32'(k == 4));
      check($sformatf("div stall_d c%0d", k), 32'(stall_d), 32'(k < 5));
    end
    check("div idle after", 32'(busy), 32'd0);

    // memwait across counter reaching zero defers the done pulse
    accept_div();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      clr_in(); rs1_d = 5'd9;
      if (k >= 3 && k <= 6) dreq = 1'b1;
      if (k == 6) drdy = 1'b1;
      #1;
      check($sformatf("mw done c%0d", k), 32'(done), 32'(k == 6));
      if (k >= 3 && k <= 5)
        check($sformatf("mw freeze c%0d", k), 32'(outv), 32'({4'b1111, 3'b001, 2'b00, 2'b00}));
      check($sformatf("mw busy c%0d", k), 32'(busy), 32'(k < 7));
    end

    // asynchronous reset mid-operation
    accept_div();
    @(negedge clk); clr_in(); rs1_d = 5'd9;
    @(negedge clk); clr_in(); rs1_d = 5'd9;
    #2 rst = 1'b1;
    #1 check("rst mid busy/done/mc_rd", 32'({busy, done, mc_rd}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      clr_in(); rs1_d = 5'd9;
      #1 check($sformatf("post-rst c%0d", k), 32'({done, busy, stall_d}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
